// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
// Pipeline hazard controller for a 5-stage RV32I core. It provides:
//   - MEM/WB -> EX operand forwarding selects
//   - load-use detection with a multi-cycle ID stall (LOAD_STALL_CYCLES)
//   - a register scoreboard for outstanding long-latency (mul/div) writebacks,
//     which detects RAW, WAW and structural (too many in flight) hazards
//   - branch flush control for the IF/ID and ID/EX pipeline registers
//
// Ports:
//   clk, reset                       clock (rising edge), async active-high reset
//   d_rs1/d_rs2/d_rd, d_uses_rs1/d_uses_rs2/d_regwren, d_lx
//                                    ID-stage register indices and usage flags
//   e_rs1/e_rs2/e_rd, e_memren, e_regwren, e_lx_issue
//                                    EX-stage indices, load flag, long-latency issue
//   m_rd/m_regwren, w_rd/w_regwren   MEM/WB destinations for forwarding
//   lx_done, lx_rd                   long-latency completion (writes RF this edge)
//   e_br_taken                       branch/jump taken in EX
//   stall_if, ifid_wren, ifid_flush, idex_flush
//                                    pipeline register controls
//   rs1_sel, rs2_sel                 forward selects: 00 RF, 01 MEM, 10 WB
//   sb_pending, sb_count, sb_full    registered scoreboard state
//
// State exposure: the load-stall counter (ldc) is the only sequencing state;
// it is observable through stall_if / idex_flush. The scoreboard state is
// exported directly on sb_pending / sb_count / sb_full.
module hazard_scoreboard_unit #(
  parameter int NUM_REGS          = 32,
  parameter int REG_AW            = $clog2(NUM_REGS),
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MAX_PENDING       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_AW-1:0]   d_rs1,
  input  logic [REG_AW-1:0]   d_rs2,
  input  logic [REG_AW-1:0]   d_rd,
  input  logic                d_uses_rs1,
  input  logic                d_uses_rs2,
  input  logic                d_regwren,
  input  logic                d_lx,
  input  logic [REG_AW-1:0]   e_rs1,
  input  logic [REG_AW-1:0]   e_rs2,
  input  logic [REG_AW-1:0]   e_rd,
  input  logic                e_memren,
  input  logic                e_regwren,
  input  logic                e_lx_issue,
  input  logic [REG_AW-1:0]   m_rd,
  input  logic [REG_AW-1:0]   w_rd,
  input  logic                m_regwren,
  input  logic                w_regwren,
  input  logic                lx_done,
  input  logic [REG_AW-1:0]   lx_rd,
  input  logic                e_br_taken,
  output logic                stall_if,
  output logic                ifid_wren,
  output logic                ifid_flush,
  output logic                idex_flush,
  output logic [1:0]          rs1_sel,
  output logic [1:0]          rs2_sel,
  output logic [NUM_REGS-1:0] sb_pending,
  output logic [REG_AW:0]     sb_count,
  output logic                sb_full
);

  localparam logic [2:0]        LDC_INIT  = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [REG_AW+1:0] MAX_PEND  = (REG_AW+2)'(MAX_PENDING);
  localparam logic [REG_AW:0]   MAX_CNT   = (REG_AW+1)'(MAX_PENDING);

  // ---------------------------------------------------------------------------
  // Forwarding (combinational). MEM is younger than WB, so it wins.
  // e_regwren is not needed here: forwarding is keyed on the producers in
  // MEM/WB; the EX write flag only matters once that instruction reaches MEM.
  // ---------------------------------------------------------------------------
  logic e_regwren_unused;
  assign e_regwren_unused = e_regwren;

  always_comb begin
    rs1_sel = 2'b00;
    if (!reset && e_rs1 != '0) begin
      if (m_regwren && m_rd == e_rs1)      rs1_sel = 2'b01;
      else if (w_regwren && w_rd == e_rs1) rs1_sel = 2'b10;
    end
  end

  always_comb begin
    rs2_sel = 2'b00;
    if (!reset && e_rs2 != '0) begin
      if (m_regwren && m_rd == e_rs2)      rs2_sel = 2'b01;
      else if (w_regwren && w_rd == e_rs2) rs2_sel = 2'b10;
    end
  end

  // ---------------------------------------------------------------------------
  // Load-use stall. The first stall cycle comes straight from load_hit while
  // ldc is still 0; ldc then counts the remaining LOAD_STALL_CYCLES-1 cycles.
  // A taken branch squashes the dependent instruction, so ldc is cleared.
  // ---------------------------------------------------------------------------
  logic       load_hit;
  logic       ld_stall;
  logic [2:0] ldc;

  assign load_hit = e_memren && (e_rd != '0) &&
                    ((d_uses_rs1 && e_rd == d_rs1) || (d_uses_rs2 && e_rd == d_rs2));
  assign ld_stall = (ldc == 3'd0 && load_hit) || (ldc != 3'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                ldc <= 3'd0;
    else if (e_br_taken)      ldc <= 3'd0;
    else if (ldc != 3'd0)     ldc <= ldc - 3'd1;
    else if (load_hit)        ldc <= LDC_INIT;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard. A register is "pending" if its bit is set or an op targeting it
  // issues from EX this cycle (the bit is not visible until the next edge).
  // lx_done is deliberately not bypassed: the hazard drops the cycle after the
  // bit clears.
  // ---------------------------------------------------------------------------
  logic pend_rs1, pend_rs2, pend_rd;
  logic [REG_AW+1:0] sb_demand;
  logic struct_hit;
  logic sb_hazard;

  assign pend_rs1 = (d_rs1 != '0) && (sb_pending[d_rs1] || (e_lx_issue && e_rd == d_rs1));
  assign pend_rs2 = (d_rs2 != '0) && (sb_pending[d_rs2] || (e_lx_issue && e_rd == d_rs2));
  assign pend_rd  = (d_rd  != '0) && (sb_pending[d_rd]  || (e_lx_issue && e_rd == d_rd));

  assign sb_demand  = {1'b0, sb_count} + (REG_AW+2)'(e_lx_issue);
  assign struct_hit = d_lx && (sb_demand >= MAX_PEND);

  assign sb_hazard = (d_uses_rs1 && pend_rs1) ||
                     (d_uses_rs2 && pend_rs2) ||
                     (d_regwren  && pend_rd)  ||
                     struct_hit;

  // Next scoreboard value: clear first, then set, so a same-edge set wins.
  logic [NUM_REGS-1:0] sb_next;
  logic [REG_AW:0]     cnt_next;

  always_comb begin
    sb_next = sb_pending;
    if (lx_done)                    sb_next[lx_rd] = 1'b0;
    if (e_lx_issue && e_rd != '0)   sb_next[e_rd]  = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_next = cnt_next + (REG_AW+1)'(sb_next[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_pending <= '0;
      sb_count   <= '0;
      sb_full    <= 1'b0;
    end else begin
      sb_pending <= sb_next;
      sb_count   <= cnt_next;
      sb_full    <= (cnt_next == MAX_CNT);
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline controls. A taken branch overrides the stall: IF must fetch the
  // target and the stalled ID instruction is on the wrong path anyway.
  // While reset is high the pipeline is held flushed.
  // ---------------------------------------------------------------------------
  logic stall;
  assign stall = ld_stall || sb_hazard;

  assign stall_if   = !reset && stall && !e_br_taken;
  assign ifid_wren  = reset || !stall || e_br_taken;
  assign ifid_flush = reset || e_br_taken;
  assign idex_flush = reset || stall || e_br_taken;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed testbench for hazard_scoreboard_unit (NUM_REGS=32,
// LOAD_STALL_CYCLES=3, MAX_PENDING=2). Inputs change 1 time unit after the
// rising edge; outputs are sampled 1 time unit after inputs change.
module tb_hazard_scoreboard_unit;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  // clock / reset
  logic clk;
  logic reset;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [REG_AW-1:0]   d_rs1, d_rs2, d_rd, e_rs1, e_rs2, e_rd, m_rd, w_rd, lx_rd;
  logic                d_uses_rs1, d_uses_rs2, d_regwren, d_lx;
  logic                e_memren, e_regwren, e_lx_issue;
  logic                m_regwren, w_regwren, lx_done, e_br_taken;
  logic                stall_if, ifid_wren, ifid_flush, idex_flush, sb_full;
  logic [1:0]          rs1_sel, rs2_sel;
  logic [NUM_REGS-1:0] sb_pending;
  logic [REG_AW:0]     sb_count;

  hazard_scoreboard_unit #(
    .NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .LOAD_STALL_CYCLES(3), .MAX_PENDING(2)
  ) dut (
    .clk(clk), .reset(reset),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
    .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2), .d_regwren(d_regwren), .d_lx(d_lx),
    .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd),
    .e_memren(e_memren), .e_regwren(e_regwren), .e_lx_issue(e_lx_issue),
    .m_rd(m_rd), .w_rd(w_rd), .m_regwren(m_regwren), .w_regwren(w_regwren),
    .lx_done(lx_done), .lx_rd(lx_rd), .e_br_taken(e_br_taken),
    .stall_if(stall_if), .ifid_wren(ifid_wren), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
    .sb_pending(sb_pending), .sb_count(sb_count), .sb_full(sb_full)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    d_rs1 = '0; d_rs2 = '0; d_rd = '0;
    d_uses_rs1 = 0; d_uses_rs2 = 0; d_regwren = 0; d_lx = 0;
    e_rs1 = '0; e_rs2 = '0; e_rd = '0;
    e_memren = 0; e_regwren = 0; e_lx_issue = 0;
    m_rd = '0; w_rd = '0; m_regwren = 0; w_regwren = 0;
    lx_done = 0; lx_rd = '0; e_br_taken = 0;
  endtask

  // advance to 1 unit after the next rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctrl(input string tag, input logic s, input logic w,
                            input logic fi, input logic fx);
    check({tag, "_stall_if"},   64'(stall_if),   64'(s));
    check({tag, "_ifid_wren"},  64'(ifid_wren),  64'(w));
    check({tag, "_ifid_flush"}, 64'(ifid_flush), 64'(fi));
    check({tag, "_idex_flush"}, 64'(idex_flush), 64'(fx));
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    // forwarding candidates present during reset must still select RF
    e_rs1 = 5'd5; m_rd = 5'd5; m_regwren = 1;
    #1;
    check_ctrl("rst", 0, 1, 1, 1);
    check("rst_rs1_sel", 64'(rs1_sel), 64'd0);
    check("rst_pending", 64'(sb_pending), 64'd0);
    check("rst_count",   64'(sb_count), 64'd0);
    check("rst_full",    64'(sb_full), 64'd0);
    #11 reset = 1'b0;
    clear_inputs();
    #1;
    check_ctrl("idle", 0, 1, 0, 0);

    // ---- forwarding ----
    e_rs1 = 5'd5; m_rd = 5'd5; m_regwren = 1; w_rd = 5'd5; w_regwren = 1;
    #1 check("fwd_mem_wins", 64'(rs1_sel), 64'd1);
    m_regwren = 0;
    #1 check("fwd_wb", 64'(rs1_sel), 64'd2);
    e_rs1 = 5'd0; m_rd = 5'd0; w_rd = 5'd0; m_regwren = 1;
    #1 check("fwd_r0", 64'(rs1_sel), 64'd0);
    e_rs2 = 5'd6; m_rd = 5'd7; w_rd = 5'd6; w_regwren = 1;
    #1 check("fwd_rs2_wb", 64'(rs2_sel), 64'd2);
    w_regwren = 0;
    #1 check("fwd_rs2_none", 64'(rs2_sel), 64'd0);
    clear_inputs();

    // ---- load-use, 3 stall cycles ----
    next_cycle();
    e_memren = 1; e_rd = 5'd7; d_rs2 = 5'd7; d_uses_rs2 = 1;
    #1 check_ctrl("ld_c1", 1, 0, 0, 1);
    next_cycle();
    e_memren = 0; e_rd = 5'd0;   // bubble now in EX
    #1 check_ctrl("ld_c2", 1, 0, 0, 1);
    next_cycle();
    #1 check_ctrl("ld_c3", 1, 0, 0, 1);
    next_cycle();
    #1 check_ctrl("ld_done", 0, 1, 0, 0);
    // load into rd 0 never hazards
    e_memren = 1; e_rd = 5'd0; d_rs2 = 5'd0;
    #1 check("ld_r0", 64'(stall_if), 64'd0);
    clear_inputs();

    // ---- branch in the 2nd stall cycle ----
    next_cycle();
    e_memren = 1; e_rd = 5'd7; d_rs1 = 5'd7; d_uses_rs1 = 1;
    #1 check("br_c1_stall", 64'(stall_if), 64'd1);
    next_cycle();
    e_memren = 0; e_rd = 5'd0; e_br_taken = 1;
    #1 check_ctrl("br_c2", 0, 1, 1, 1);
    next_cycle();
    e_br_taken = 0;
    #1 check_ctrl("br_after", 0, 1, 0, 0);
    clear_inputs();

    // ---- scoreboard RAW / WAW ----
    next_cycle();
    e_lx_issue = 1; e_rd = 5'd9; d_rs1 = 5'd9; d_uses_rs1 = 1;
    #1 check("sb_raw_issue_bypass", 64'(stall_if), 64'd1);
    next_cycle();
    e_lx_issue = 0; e_rd = 5'd0;
    #1;
    check("sb_pending_9", 64'(sb_pending), 64'h200);
    check("sb_count_1",   64'(sb_count), 64'd1);
    check_ctrl("sb_raw", 1, 0, 0, 1);
    next_cycle();
    #1 check("sb_raw_hold", 64'(stall_if), 64'd1);
    d_uses_rs1 = 0; d_rd = 5'd9; d_regwren = 1;
    #1 check("sb_waw", 64'(stall_if), 64'd1);
    lx_done = 1; lx_rd = 5'd9;
    #1 check("sb_no_done_bypass", 64'(stall_if), 64'd1);
    next_cycle();
    lx_done = 0;
    #1;
    check("sb_cleared", 64'(sb_pending), 64'd0);
    check("sb_cleared_cnt", 64'(sb_count), 64'd0);
    check("sb_waw_drop", 64'(stall_if), 64'd0);
    d_regwren = 0; d_rd = 5'd0;

    // same-edge issue and completion of reg 9: set wins
    e_lx_issue = 1; e_rd = 5'd9; lx_done = 1; lx_rd = 5'd9;
    next_cycle();
    #1 check("sb_set_wins", 64'(sb_pending), 64'h200);
    // issue to r0 is ignored; completion of 9 clears
    e_rd = 5'd0; lx_rd = 5'd9;
    next_cycle();
    #1 check("sb_r0_clear", 64'(sb_pending), 64'd0);
    // completion of a non-pending reg is a no-op
    e_lx_issue = 0; lx_rd = 5'd12;
    next_cycle();
    lx_done = 0;
    #1 check("sb_noop_cnt", 64'(sb_count), 64'd0);
    clear_inputs();

    // ---- structural, MAX_PENDING=2 ----
    e_lx_issue = 1; e_rd = 5'd3; d_lx = 1;
    #1 check("st_0plus1", 64'(stall_if), 64'd0);
    next_cycle();
    e_rd = 5'd4;
    #1 check("st_1plus1", 64'(stall_if), 64'd1);
    next_cycle();
    e_lx_issue = 0; e_rd = 5'd0;
    #1;
    check("st_count", 64'(sb_count), 64'd2);
    check("st_full",  64'(sb_full), 64'd1);
    check("st_pend",  64'(sb_pending), 64'h18);
    check("st_stall", 64'(stall_if), 64'd1);
    lx_done = 1; lx_rd = 5'd3;
    #1 check("st_done_same", 64'(stall_if), 64'd1);
    next_cycle();
    lx_done = 0;
    #1;
    check("st_count_1", 64'(sb_count), 64'd1);
    check("st_not_full", 64'(sb_full), 64'd0);
    check("st_drop", 64'(stall_if), 64'd0);
    clear_inputs();

    // ---- async reset mid-stall (ldc=2, sb_pending[4] set) ----
    next_cycle();
    e_memren = 1; e_rd = 5'd7; d_rs1 = 5'd7; d_uses_rs1 = 1;
    next_cycle();
    e_memren = 0; e_rd = 5'd0;
    #1 check("ar_pre_stall", 64'(stall_if), 64'd1);
    e_rs1 = 5'd5; m_rd = 5'd5; m_regwren = 1;
    #1 reset = 1'b1;
    #1;
    check_ctrl("ar", 0, 1, 1, 1);
    check("ar_rs1_sel",  64'(rs1_sel), 64'd0);
    check("ar_pending",  64'(sb_pending), 64'd0);
    check("ar_count",    64'(sb_count), 64'd0);
    check("ar_full",     64'(sb_full), 64'd0);
    #1 reset = 1'b0;
    clear_inputs();
    d_rs1 = 5'd4; d_uses_rs1 = 1;   // reg 4 no longer pending
    #1 check_ctrl("ar_rel", 0, 1, 0, 0);
    next_cycle();
    #1 check_ctrl("ar_rel_next", 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Next-generation pipeline hazard controller for the 5-stage RV32I core. It keeps MEM/WB→EX forwarding, load-use detection and branch flush. It adds a parametrised multi-cycle load-use stall for slower data memory, and a register scoreboard tracking outstanding long-latency (mul/div) writebacks. It sits beside the pipeline registers and drives their write-enable and flush controls.

Parameters:
NUM_REGS, 32, architectural register count (power of 2, ≥2).
REG_AW, $clog2(NUM_REGS), register index width.
LOAD_STALL_CYCLES, 1, ID stall cycles per load-use hazard (1..7).
MAX_PENDING, 4, max outstanding long-latency ops (1..NUM_REGS-1).

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high
d_rs1, d_rs2, d_rd  in  REG_AW each  ID-stage register indices
d_uses_rs1, d_uses_rs2, d_regwren  in  1 each  ID instr reads rs1 / reads rs2 / writes rd
d_lx  in  1  ID instr is long-latency
e_rs1, e_rs2, e_rd  in  REG_AW each  EX-stage indices
e_memren, e_regwren  in  1 each  EX is load / EX writes rd via normal path
e_lx_issue  in  1  EX instr is long-latency and issues this cycle
m_rd, w_rd  in  REG_AW each  MEM/WB destination
m_regwren, w_regwren  in  1 each  MEM/WB write enables (0 for long-latency ops)
lx_done  in  1  long-latency unit writes RF this edge
lx_rd  in  REG_AW  destination of completing op
e_br_taken  in  1  branch/jump taken in EX
stall_if  out  1  hold PC
ifid_wren  out  1  IF/ID write enable
ifid_flush  out  1  clear IF/ID
idex_flush  out  1  bubble into ID/EX
rs1_sel, rs2_sel  out  2 each  00 RF, 01 MEM, 10 WB
sb_pending  out  NUM_REGS  registered scoreboard bit vector
sb_count  out  REG_AW+1  popcount of sb_pending
sb_full  out  1  sb_count == MAX_PENDING

Behaviour:
- Reg 0 never forwards, never hazards, never marks pending.
- Forwarding is combinational. MEM match (m_regwren, m_rd==e_rsX) beats WB match. Otherwise 00.
- load_hit: e_memren && e_rd!=0 && ((d_uses_rs1 && e_rd==d_rs1) || (d_uses_rs2 && e_rd==d_rs2)).
- Load-stall counter ldc (3 bits, reset 0):
  - If ldc==0 and load_hit and !e_br_taken, load ldc ← LOAD_STALL_CYCLES-1.
  - If ldc>0, decrement.
  - e_br_taken forces ldc ← 0.
- ld_stall = (ldc==0 && load_hit) || ldc>0. Total stall per hazard is exactly LOAD_STALL_CYCLES cycles.
- Scoreboard:
  - Set bit e_rd at the edge when e_lx_issue && e_rd!=0.
  - Clear bit lx_rd at the edge when lx_done. lx_done on a non-pending reg is a no-op.
  - Same-edge set and clear of the same reg: set wins.
  - sb_count/sb_full are registered, consistent with sb_pending after each edge.
- sb_hazard, any of:
  - d_uses_rs1 && pend(d_rs1)
  - d_uses_rs2 && pend(d_rs2)
  - d_regwren && pend(d_rd) (WAW)
  - d_lx && (sb_count + e_lx_issue ≥ MAX_PENDING) (structural)
  - where pend(r) = r!=0 && (sb_pending[r] || (e_lx_issue && e_rd==r)).
  - No same-cycle bypass from lx_done: the hazard clears the cycle after the bit clears.
- stall = ld_stall || sb_hazard.
- Control outputs:
  - stall_if = stall && !e_br_taken
  - ifid_wren = !stall || e_br_taken
  - ifid_flush = e_br_taken
  - idex_flush = stall || e_br_taken
- Branch never clears scoreboard bits (older ops still complete).
- Reset (async, any time, incl. mid-stall):
  - ldc=0, sb_pending=0, sb_count=0, sb_full=0.
  - While reset is high: stall_if=0, ifid_wren=1, ifid_flush=1, idex_flush=1, rs1_sel=rs2_sel=00.

Test Plan:
- Forwarding: e_rs1=5, m_rd=5/m_regwren=1, w_rd=5/w_regwren=1 → rs1_sel=01. Drop m_regwren → 10. e_rs1=0 with both matching → 00.
- Load-use, LOAD_STALL_CYCLES=3: e_memren, e_rd=7, d_rs2=7, d_uses_rs2=1 → stall_if=1, ifid_wren=0, idex_flush=1 for exactly 3 cycles; then stall_if=0.
- Branch mid-stall, LOAD_STALL_CYCLES=3: assert e_br_taken in the 2nd stall cycle → that cycle stall_if=0, ifid_flush=1, idex_flush=1. Next cycle stall_if=0 (ldc cleared).
- Scoreboard RAW/WAW: issue lx rd=9; ID d_rs1=9 → stall every cycle until the cycle after lx_done with lx_rd=9. With d_rd=9, d_regwren=1 → same stall. Same-edge issue rd=9 and lx_done rd=9 → sb_pending[9] stays 1.
- Structural, MAX_PENDING=2: issue rd=3 and rd=4 → sb_full=1, sb_count=2. d_lx=1 stalls. lx_done rd=3 → sb_count=1, stall drops next cycle.
- Async reset with sb_pending nonzero and ldc=2 → outputs go to reset values immediately. After release, no stall.
